if_id_stage: RTL and testbench
==============================

# if_id_stage

Instruction-fetch front end and IF/ID pipeline register for the 5-stage RISC-V pipeline. It owns the program counter and issues fetches to a variable-latency instruction memory. It presents the fetched instruction and its PC to the ID stage. It obeys the load-use hold from hazard detection (`PCWrite_i`, `Stall_i`) and the branch flush from ID (`Flush_i`, `BranchTarget_i`).

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `clk_i` input 1: single clock, all state updates on rising edge.
- `rst_i` input 1: reset, asynchronous, active-high.
- `start_i` input 1: level; fetching begins on the first rising edge where it is high.
- `PCWrite_i` input 1: 0 means hold the PC (from hazard detection).
- `Stall_i` input 1: 1 means hold the IF/ID register (from hazard detection).
- `Flush_i` input 1: 1 means squash the fetched instruction and redirect to `BranchTarget_i`.
- `BranchTarget_i` input 32: redirect address, sampled when `Flush_i`=1.
- `ImemReq_o` output 1: fetch request outstanding.
- `ImemAddr_o` output 32: fetch address; stable while `ImemReq_o`=1.
- `ImemValid_i` input 1: one-cycle pulse; `ImemInstr_i` is valid this cycle.
- `ImemInstr_i` input 32: fetched instruction word.
- `IDPC_o` output 32: IF/ID register, PC of the instruction.
- `IDInstr_o` output 32: IF/ID register, instruction word.
- `IDValid_o` output 1: IF/ID register, 1 = real instruction, 0 = bubble.

## Operation
- Hold condition: `hold = Stall_i | ~PCWrite_i`. `Flush_i` has priority over `hold` in every state.
- Internal registers:
  - `PC`: 32-bit program counter.
  - `RedirectPC`: 32-bit pending redirect target.
  - `Buf`: 32-bit skid buffer for a received instruction.
  - `state`: one of IDLE, REQ, HOLD, DROP.
- Outputs in each state:
  - `ImemReq_o` = (state==REQ or DROP).
  - `ImemAddr_o` = `PC`. `PC` never changes while a request is outstanding.
- IDLE: no request. Go to REQ when `start_i`=1.
- REQ, with `ImemValid_i`=1:
  - If `Flush_i`: discard the instruction, `PC`<=`BranchTarget_i`, IF/ID valid<=0, stay in REQ.
  - Else if `hold`: `Buf`<=instruction, IF/ID unchanged, go to HOLD.
  - Else: IF/ID<={`PC`, instruction, 1}, `PC`<=`PC`+4 (mod 2^32), stay in REQ.
- REQ, with `ImemValid_i`=0:
  - If `Flush_i`: `RedirectPC`<=`BranchTarget_i`, IF/ID valid<=0, go to DROP.
  - Else if `hold`: IF/ID unchanged.
  - Else: IF/ID valid<=0 (bubble); IF/ID PC and instruction fields keep their old values.
- HOLD, no request outstanding:
  - If `Flush_i`: drop `Buf`, `PC`<=`BranchTarget_i`, IF/ID valid<=0, go to REQ.
  - Else if `~hold`: IF/ID<={`PC`, `Buf`, 1}, `PC`<=`PC`+4, go to REQ.
  - Else stay in HOLD.
- DROP, waiting out the squashed in-flight request:
  - A new `Flush_i` updates `RedirectPC`.
  - On `ImemValid_i`: discard the data, `PC`<=`RedirectPC` (or `BranchTarget_i` if `Flush_i` is high the same cycle), go to REQ.
  - IF/ID valid is forced to 0 every cycle while in DROP, unless `hold` is high and no flush is present; in that case IF/ID is unchanged.
- `start_i` is only examined in IDLE. Deasserting it later has no effect.

## Timing
- Reset, asynchronous, immediate:
  - state=IDLE, `PC`=`RESET_PC`, `RedirectPC`=0, `Buf`=0.
  - `ImemReq_o`=0, `ImemAddr_o`=`RESET_PC`.
  - `IDPC_o`=0, `IDInstr_o`=0, `IDValid_o`=0.
- Reset asserted mid-request abandons the outstanding request. After reset release, the bench or memory model must not deliver a stale `ImemValid_i`.
- Latency:
  - Instruction accepted at edge N (`ImemValid_i`=1, no hold, no flush) appears on `IDValid_o`/`IDInstr_o` after edge N.
  - The next request address (`PC`+4) is presented in the cycle after edge N.
- With a zero-wait memory (`ImemValid_i` high in every REQ cycle), throughput is one instruction per cycle.
- After HOLD releases: the buffered instruction is registered at the release edge, and the next request issues the following cycle. This costs one fetch bubble; no instruction is lost or duplicated.
- A flush squashes the IF/ID register at the same edge the flush is sampled. The first target instruction reaches ID no earlier than 1 cycle after the target request is accepted.
- `PC` wraps from 32'hFFFF_FFFC to 32'h0000_0000.

## Test plan
1. Reset, then `start_i`=1 with a zero-wait memory returning word = address → `IDPC_o` = 0, 4, 8, … on consecutive cycles, with `IDValid_o`=1 from the 2nd edge after start.
2. Memory with a 3-cycle response, no hazards → `ImemAddr_o` is held for 3 cycles per fetch, and `IDValid_o` pulses 1 for one cycle per fetch.
3. `Stall_i`=1, `PCWrite_i`=0 for 2 cycles, arriving in the same cycle as the response for PC=0x10 → IF/ID keeps the previous instruction while the hold is active. The cycle after release shows PC=0x10, valid=1; the next fetch address is 0x14.
4. `Flush_i`=1, `BranchTarget_i`=0x100, while a fetch of 0x20 is pending → `IDValid_o`=0 next cycle. The 0x20 response is discarded, the next `ImemAddr_o`=0x100, and `IDPC_o`=0x100 appears with valid=1.
5. `Flush_i` and `hold` asserted in the same HOLD cycle → the buffer is dropped, the next fetch is `BranchTarget_i`, and `IDValid_o`=0.
6. `rst_i` pulsed mid-request with `PC`=0x40 → all outputs return to their reset values within the same cycle, and fetch restarts from `RESET_PC` only after `start_i`.

Source files
------------

// File: rtl/if_id_stage_if.sv
// Fetch/decode boundary bundle: hazard controls, instruction-memory handshake
// and the IF/ID register outputs presented to the decode stage.
interface if_id_stage_if;
    logic        start_i;
    logic        PCWrite_i;
    logic        Stall_i;
    logic        Flush_i;
    logic [31:0] BranchTarget_i;
    logic        ImemReq_o;
    logic [31:0] ImemAddr_o;
    logic        ImemValid_i;
    logic [31:0] ImemInstr_i;
    logic [31:0] IDPC_o;
    logic [31:0] IDInstr_o;
    logic        IDValid_o;

    modport master (
        output start_i, PCWrite_i, Stall_i, Flush_i, BranchTarget_i,
        output ImemValid_i, ImemInstr_i,
        input  ImemReq_o, ImemAddr_o, IDPC_o, IDInstr_o, IDValid_o
    );

    modport slave (
        input  start_i, PCWrite_i, Stall_i, Flush_i, BranchTarget_i,
        input  ImemValid_i, ImemInstr_i,
        output ImemReq_o, ImemAddr_o, IDPC_o, IDInstr_o, IDValid_o
    );
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch front end: owns the PC, talks to a variable-latency imem and
// drives the IF/ID pipeline register, honouring load-use hold and branch flush.
//   state  | meaning
//   IDLE   | waiting for start, no request
//   REQ    | fetch of r_pc outstanding
//   HOLD   | fetched word parked in r_buf while decode is held
//   DROP   | squashed fetch still in flight, redirect pending
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    if_id_stage_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_buf;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic        r_id_valid;
    logic        r_imem_req;

    logic        w_hold;
    logic [31:0] w_pc_inc;

    assign w_hold   = bus.Stall_i | ~bus.PCWrite_i;
    assign w_pc_inc = r_pc + 32'd4;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_redirect_pc <= 32'd0;
            r_buf         <= 32'd0;
            r_id_pc       <= 32'd0;
            r_id_instr    <= 32'd0;
            r_id_valid    <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end
                end

                S_REQ: begin
                    if (bus.ImemValid_i) begin
                        if (bus.Flush_i) begin
                            r_pc       <= bus.BranchTarget_i;
                            r_id_valid <= 1'b0;
                        end else if (w_hold) begin
                            r_buf      <= bus.ImemInstr_i;
                            r_state    <= S_HOLD;
                            r_imem_req <= 1'b0;
                        end else begin
                            r_id_pc    <= r_pc;
                            r_id_instr <= bus.ImemInstr_i;
                            r_id_valid <= 1'b1;
                            r_pc       <= w_pc_inc;
                        end
                    end else if (bus.Flush_i) begin
                        // PC must stay put until the in-flight word arrives
                        r_redirect_pc <= bus.BranchTarget_i;
                        r_id_valid    <= 1'b0;
                        r_state       <= S_DROP;
                    end else if (!w_hold) begin
                        r_id_valid <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (bus.Flush_i) begin
                        r_pc       <= bus.BranchTarget_i;
                        r_id_valid <= 1'b0;
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end else if (!w_hold) begin
                        r_id_pc    <= r_pc;
                        r_id_instr <= r_buf;
                        r_id_valid <= 1'b1;
                        r_pc       <= w_pc_inc;
                        r_state    <= S_REQ;
                        r_imem_req <= 1'b1;
                    end
                end

                S_DROP: begin
                    if (bus.Flush_i) begin
                        r_redirect_pc <= bus.BranchTarget_i;
                    end
                    if (bus.Flush_i || !w_hold) begin
                        r_id_valid <= 1'b0;
                    end
                    if (bus.ImemValid_i) begin
                        r_pc    <= bus.Flush_i ? bus.BranchTarget_i : r_redirect_pc;
                        r_state <= S_REQ;
                    end
                end

                default: begin
                    r_state    <= S_IDLE;
                    r_imem_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ImemReq_o  = r_imem_req;
    assign bus.ImemAddr_o = r_pc;
    assign bus.IDPC_o     = r_id_pc;
    assign bus.IDInstr_o  = r_id_instr;
    assign bus.IDValid_o  = r_id_valid;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed plus randomized bench for if_id_stage: a transaction-level fetch model
// and a variable-latency memory responder predict every output each cycle.
module tb_if_id_stage;
    logic clk = 1'b0;
    logic rst;

    if_id_stage_if bus();

    if_id_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: fetch unit described by what it is doing, not by FSM state.
    bit          m_run;
    bit          m_buf_full;
    bit          m_squash;
    logic [31:0] m_pc;
    logic [31:0] m_redir;
    logic [31:0] m_buf;
    logic [31:0] m_idpc;
    logic [31:0] m_idinstr;
    bit          m_idv;

    int          mem_cnt;
    int          mem_lat;
    bit          mem_rand;
    logic [31:0] mem_xor;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int next_lat();
        if (mem_rand) return int'($urandom_range(0, 3));
        return mem_lat;
    endfunction

    task automatic model_reset();
        m_run      = 1'b0;
        m_buf_full = 1'b0;
        m_squash   = 1'b0;
        m_pc       = 32'h0000_0000;
        m_redir    = 32'd0;
        m_buf      = 32'd0;
        m_idpc     = 32'd0;
        m_idinstr  = 32'd0;
        m_idv      = 1'b0;
        mem_cnt    = mem_lat;
    endtask

    task automatic check_outputs();
        chk("req",     32'(bus.ImemReq_o), 32'(m_run && !m_buf_full));
        chk("addr",    bus.ImemAddr_o, m_pc);
        chk("idpc",    bus.IDPC_o, m_idpc);
        chk("idinstr", bus.IDInstr_o, m_idinstr);
        chk("idvalid", 32'(bus.IDValid_o), 32'(m_idv));
    endtask

    // Called just after a falling edge: check, drive one cycle, predict, advance.
    task automatic step(input bit st, input bit pw, input bit sl, input bit fl,
                        input logic [31:0] tgt);
        bit          v;
        bit          hold;
        logic [31:0] w;
        check_outputs();
        v = 1'b0;
        w = $urandom;
        if (m_run && !m_buf_full) begin
            if (mem_cnt == 0) begin
                v       = 1'b1;
                w       = m_pc ^ mem_xor;
                mem_cnt = next_lat();
            end else begin
                mem_cnt--;
            end
        end
        bus.start_i        = st;
        bus.PCWrite_i      = pw;
        bus.Stall_i        = sl;
        bus.Flush_i        = fl;
        bus.BranchTarget_i = tgt;
        bus.ImemValid_i    = v;
        bus.ImemInstr_i    = w;

        hold = sl | ~pw;
        if (!m_run) begin
            if (st) m_run = 1'b1;
        end else if (m_buf_full) begin
            if (fl) begin
                m_buf_full = 1'b0;
                m_pc       = tgt;
                m_idv      = 1'b0;
            end else if (!hold) begin
                m_idpc     = m_pc;
                m_idinstr  = m_buf;
                m_idv      = 1'b1;
                m_pc       = m_pc + 32'd4;
                m_buf_full = 1'b0;
            end
        end else if (m_squash) begin
            if (fl) m_redir = tgt;
            if (!(hold && !fl)) m_idv = 1'b0;
            if (v) begin
                m_pc     = m_redir;
                m_squash = 1'b0;
            end
        end else if (v) begin
            if (fl) begin
                m_pc  = tgt;
                m_idv = 1'b0;
            end else if (hold) begin
                m_buf      = w;
                m_buf_full = 1'b1;
            end else begin
                m_idpc    = m_pc;
                m_idinstr = w;
                m_idv     = 1'b1;
                m_pc      = m_pc + 32'd4;
            end
        end else begin
            if (fl) begin
                m_redir  = tgt;
                m_idv    = 1'b0;
                m_squash = 1'b1;
            end else if (!hold) begin
                m_idv = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int          pulses;
        logic [31:0] r;

        rst                = 1'b1;
        bus.start_i        = 1'b0;
        bus.PCWrite_i      = 1'b1;
        bus.Stall_i        = 1'b0;
        bus.Flush_i        = 1'b0;
        bus.BranchTarget_i = 32'd0;
        bus.ImemValid_i    = 1'b0;
        bus.ImemInstr_i    = 32'd0;
        mem_lat  = 0;
        mem_rand = 1'b0;
        mem_xor  = 32'd0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;

        // Idle without start: nothing happens
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);

        // Zero-wait streaming, word == address
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("t1_pc0", bus.IDPC_o, 32'h0);
        chk("t1_v0", 32'(bus.IDValid_o), 32'd1);
        step(0, 1, 0, 0, 0);
        chk("t1_pc4", bus.IDPC_o, 32'h4);
        step(0, 1, 0, 0, 0);
        chk("t1_pc8", bus.IDPC_o, 32'h8);
        step(0, 1, 0, 0, 0);
        chk("t1_pcc", bus.IDPC_o, 32'hC);

        // Hold arrives with the 0x10 response
        step(0, 0, 1, 0, 0);
        chk("t3_hold1_pc", bus.IDPC_o, 32'hC);
        step(0, 0, 1, 0, 0);
        chk("t3_hold2_pc", bus.IDPC_o, 32'hC);
        chk("t3_hold2_req", 32'(bus.ImemReq_o), 32'd0);
        step(0, 1, 0, 0, 0);
        chk("t3_rel_pc", bus.IDPC_o, 32'h10);
        chk("t3_rel_instr", bus.IDInstr_o, 32'h10);
        chk("t3_rel_v", 32'(bus.IDValid_o), 32'd1);
        chk("t3_next_addr", bus.ImemAddr_o, 32'h14);
        step(0, 1, 0, 0, 0);

        // Three-cycle memory
        mem_lat = 2;
        mem_cnt = 2;
        pulses  = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 0, 0, 0);
            pulses += int'(bus.IDValid_o);
        end
        chk("t2_pulses", 32'(pulses), 32'd2);
        chk("t2_addr", bus.ImemAddr_o, 32'h20);

        // Flush while 0x20 is in flight
        step(0, 1, 0, 1, 32'h100);
        chk("t4_squash_v", 32'(bus.IDValid_o), 32'd0);
        chk("t4_addr_kept", bus.ImemAddr_o, 32'h20);
        for (int i = 0; i < 10 && m_squash; i++) step(0, 1, 0, 0, 0);
        chk("t4_redirect_addr", bus.ImemAddr_o, 32'h100);
        for (int i = 0; i < 10 && !(m_idv && m_idpc == 32'h100); i++) step(0, 1, 0, 0, 0);
        chk("t4_target_pc", bus.IDPC_o, 32'h100);
        chk("t4_target_v", 32'(bus.IDValid_o), 32'd1);

        // Flush and hold together while holding a buffered word
        mem_lat = 0;
        mem_cnt = 0;
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 32'h200);
        chk("t5_v", 32'(bus.IDValid_o), 32'd0);
        chk("t5_addr", bus.ImemAddr_o, 32'h200);
        chk("t5_req", 32'(bus.ImemReq_o), 32'd1);
        step(0, 1, 0, 0, 0);
        chk("t5_pc", bus.IDPC_o, 32'h200);

        // PC wrap
        step(0, 1, 0, 1, 32'hFFFF_FFF8);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("wrap_addr", bus.ImemAddr_o, 32'h0);
        chk("wrap_idpc", bus.IDPC_o, 32'hFFFF_FFFC);

        // Reset in the middle of a request at 0x40
        mem_lat = 2;
        step(0, 1, 0, 1, 32'h40);
        step(0, 1, 0, 0, 0);
        chk("t6_pre_addr", bus.ImemAddr_o, 32'h40);
        #2 rst = 1'b1;
        bus.ImemValid_i = 1'b0;
        bus.Flush_i     = 1'b0;
        bus.start_i     = 1'b0;
        #1;
        chk("t6_req", 32'(bus.ImemReq_o), 32'd0);
        chk("t6_addr", bus.ImemAddr_o, 32'h0);
        chk("t6_idpc", bus.IDPC_o, 32'h0);
        chk("t6_idinstr", bus.IDInstr_o, 32'h0);
        chk("t6_idv", 32'(bus.IDValid_o), 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
        chk("t6_restart_pc", bus.IDPC_o, 32'h0);

        // Randomized traffic with random memory latency
        mem_rand = 1'b1;
        mem_xor  = 32'hA5C3_5A3C;
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            step(1'b1,
                 ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 7) == 0),
                 {r[31:2], 2'b00});
        end
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
